// File: rtl/chan_pkg.sv
// Shared types and helpers for the burst error channel and related PRNG-based blocks.
package chan_pkg;

  typedef enum logic [1:0] {CH_OFF, CH_RANDOM, CH_BURST, CH_FIXED} chan_mode_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr32
  import chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] seed_safe;
  assign seed_safe = (seed == 32'd0) ? 32'd1 : seed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= seed_safe;
    end else if (adv) begin
      q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'd0);
    end
  end

endmodule

// File: rtl/burst_error_channel.sv
// Channel model between convolutional encoder and Viterbi decoder: passes each valid symbol
// through or XORs an error mask into it (random, burst or fixed-period), with statistics.
module burst_error_channel
  import chan_pkg::*;
#(
  parameter int unsigned W    = 2,
  parameter int unsigned CW   = 16,
  parameter int unsigned RW   = 5,
  parameter int unsigned BW   = 4,
  parameter logic [31:0] SEED = 32'hACE1_1D5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [W-1:0]  sym_i,
  input  logic [1:0]    mode_i,
  input  logic [RW-1:0] rate_i,
  input  logic [BW-1:0] burst_len_i,
  input  logic [W-1:0]  err_mask_i,
  input  logic [CW-1:0] window_i,
  output logic          valid_o,
  output logic [W-1:0]  sym_o,
  output logic [W-1:0]  err_o,
  output logic          burst_active_o,
  output logic [CW-1:0] sym_ct_o,
  output logic [CW-1:0] inj_ct_o,
  output logic [CW-1:0] bad_bit_ct_o
);

  logic [31:0]   lfsr_q;
  logic          valid_q;
  logic [W-1:0]  sym_q, err_q;
  logic [BW-1:0] burst_q, burst_d, burst_len_eff;
  logic [CW-1:0] sym_ct_q, sym_ct_d, inj_ct_q, inj_ct_d, bad_q, bad_d;
  logic [CW:0]   bad_sum;
  logic [31:0]   rate_mask;
  logic          trig_rand, trig_fix, in_win, inject;
  logic [W-1:0]  flip;
  chan_mode_t    mode;

  // The LFSR steps after this symbol's trigger has been sampled from its current value.
  lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (valid_i),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign mode          = chan_mode_t'(mode_i);
  // k == 0 gives an empty mask, so both triggers fire on every symbol.
  assign rate_mask     = (32'd1 << rate_i) - 32'd1;
  assign trig_rand     = (lfsr_q & rate_mask) == rate_mask;
  assign trig_fix      = (32'(sym_ct_q) & rate_mask) == rate_mask;
  assign in_win        = (window_i == '0) || (sym_ct_q < window_i);
  assign burst_len_eff = (burst_len_i == '0) ? BW'(1) : burst_len_i;

  // Burst state only survives while in BURST mode and inside the window.
  always_comb begin
    inject  = 1'b0;
    burst_d = '0;
    unique case (mode)
      CH_OFF:    inject = 1'b0;
      CH_RANDOM: inject = in_win && trig_rand;
      CH_FIXED:  inject = in_win && trig_fix;
      CH_BURST: begin
        if (in_win && (burst_q != '0)) begin
          inject  = 1'b1;
          burst_d = burst_q - BW'(1);
        end else if (in_win && trig_rand) begin
          inject  = 1'b1;
          burst_d = burst_len_eff - BW'(1);
        end
      end
    endcase
  end

  assign flip     = inject ? err_mask_i : '0;
  assign sym_ct_d = (sym_ct_q == '1) ? sym_ct_q : sym_ct_q + CW'(1);
  assign inj_ct_d = (!inject || (inj_ct_q == '1)) ? inj_ct_q : inj_ct_q + CW'(1);
  assign bad_sum  = {1'b0, bad_q} + (CW+1)'(popcount(32'(flip)));
  assign bad_d    = bad_sum[CW] ? '1 : bad_sum[CW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      sym_q    <= '0;
      err_q    <= '0;
      burst_q  <= '0;
      sym_ct_q <= '0;
      inj_ct_q <= '0;
      bad_q    <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        sym_q    <= sym_i ^ flip;
        err_q    <= flip;
        burst_q  <= burst_d;
        sym_ct_q <= sym_ct_d;
        inj_ct_q <= inj_ct_d;
        bad_q    <= bad_d;
      end
    end
  end

  assign valid_o        = valid_q;
  assign sym_o          = sym_q;
  assign err_o          = err_q;
  assign burst_active_o = (burst_q != '0);
  assign sym_ct_o       = sym_ct_q;
  assign inj_ct_o       = inj_ct_q;
  assign bad_bit_ct_o   = bad_q;

endmodule

// File: tb/tb_burst_error_channel.sv
// Randomized bench for burst_error_channel against a behavioural channel model.
module tb_burst_error_channel;

  localparam int unsigned W    = 2;
  localparam int unsigned CW   = 16;
  localparam int unsigned RW   = 5;
  localparam int unsigned BW   = 4;
  localparam logic [31:0] SEED = 32'hACE1_1D5;
  localparam int          CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [W-1:0]  sym_i;
  logic [1:0]    mode_i;
  logic [RW-1:0] rate_i;
  logic [BW-1:0] burst_len_i;
  logic [W-1:0]  err_mask_i;
  logic [CW-1:0] window_i;
  logic          valid_o;
  logic [W-1:0]  sym_o;
  logic [W-1:0]  err_o;
  logic          burst_active_o;
  logic [CW-1:0] sym_ct_o;
  logic [CW-1:0] inj_ct_o;
  logic [CW-1:0] bad_bit_ct_o;

  burst_error_channel #(
    .W    (W),
    .CW   (CW),
    .RW   (RW),
    .BW   (BW),
    .SEED (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .sym_i          (sym_i),
    .mode_i         (mode_i),
    .rate_i         (rate_i),
    .burst_len_i    (burst_len_i),
    .err_mask_i     (err_mask_i),
    .window_i       (window_i),
    .valid_o        (valid_o),
    .sym_o          (sym_o),
    .err_o          (err_o),
    .burst_active_o (burst_active_o),
    .sym_ct_o       (sym_ct_o),
    .inj_ct_o       (inj_ct_o),
    .bad_bit_ct_o   (bad_bit_ct_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: plain integers, remaining burst symbols, and the reference LFSR.
  bit [31:0] m_lfsr;
  int        m_sym_ct, m_inj, m_bad, m_left;
  bit        m_valid;
  bit [1:0]  m_sym, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] lfsr_next(input bit [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_sym_ct = 0; m_inj = 0; m_bad = 0; m_left = 0;
    m_valid = 0; m_sym = 0; m_err = 0;
  endtask

  // One channel symbol, evaluated from the current input values.
  task automatic model_step(input bit v);
    longint period;
    bit     in_win, trig_r, trig_f, inj;
    int     len;
    if (v) begin
      period = longint'(1) << rate_i;
      in_win = (window_i == 0) || (m_sym_ct < int'(window_i));
      trig_r = (longint'(m_lfsr) % period) == period - 1;
      trig_f = ((longint'(m_sym_ct) + 1) % period) == 0;
      len    = (burst_len_i == 0) ? 1 : int'(burst_len_i);
      inj    = 0;
      case (mode_i)
        2'd1: inj = in_win && trig_r;
        2'd3: inj = in_win && trig_f;
        2'd2: begin
          if (!in_win) m_left = 0;
          else if (m_left > 0) begin inj = 1; m_left--; end
          else if (trig_r) begin inj = 1; m_left = len - 1; end
        end
        default: ;
      endcase
      if (mode_i != 2'd2) m_left = 0;
      m_err = inj ? err_mask_i : 2'b00;
      m_sym = sym_i ^ m_err;
      if (inj) begin
        m_inj = sat(m_inj + 1);
        m_bad = sat(m_bad + $countones(err_mask_i));
      end
      m_sym_ct = sat(m_sym_ct + 1);
      m_lfsr   = lfsr_next(m_lfsr);
    end
    m_valid = v;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid_o"}, 32'(valid_o), 32'(m_valid));
    check_eq({tag, ".sym_o"}, 32'(sym_o), 32'(m_sym));
    check_eq({tag, ".err_o"}, 32'(err_o), 32'(m_err));
    check_eq({tag, ".burst_active_o"}, 32'(burst_active_o), 32'(m_left != 0));
    check_eq({tag, ".sym_ct_o"}, 32'(sym_ct_o), 32'(m_sym_ct));
    check_eq({tag, ".inj_ct_o"}, 32'(inj_ct_o), 32'(m_inj));
    check_eq({tag, ".bad_bit_ct_o"}, 32'(bad_bit_ct_o), 32'(m_bad));
  endtask

  task automatic cycle(input bit v, input logic [1:0] s, input bit chk, input string tag);
    valid_i = v;
    sym_i   = s;
    model_step(v);
    @(posedge clk);
    #1;
    if (chk) compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b0;
    valid_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all(tag);
    rst = 1'b1;
  endtask

  task automatic config_ch(input logic [1:0] m, input int k, input int l, input logic [1:0] mk,
                           input int win);
    mode_i      = m;
    rate_i      = RW'(k);
    burst_len_i = BW'(l);
    err_mask_i  = mk;
    window_i    = CW'(win);
  endtask

  int inj_at_256;
  int nv;

  initial begin
    rst = 1'b0; valid_i = 1'b0; sym_i = '0;
    config_ch(2'd0, 0, 0, 2'b00, 0);
    @(posedge clk); #1;
    do_reset("rst0");
    check_eq("rst0.sym_ct_zero", 32'(sym_ct_o), 32'd0);

    // 1: OFF, transparent pass-through.
    config_ch(2'd0, 3, 4, 2'b11, 0);
    for (int i = 0; i < 1000; i++) cycle(1'b1, 2'($urandom), 1'b1, "t1");
    check_eq("t1.sym_ct", 32'(sym_ct_o), 32'd1000);
    check_eq("t1.inj", 32'(inj_ct_o), 32'd0);

    // 2: FIXED k=2 -> every 4th symbol.
    do_reset("rst2");
    config_ch(2'd3, 2, 1, 2'b10, 0);
    for (int i = 0; i < 64; i++) cycle(1'b1, 2'($urandom), 1'b1, "t2");
    check_eq("t2.inj", 32'(inj_ct_o), 32'd16);
    check_eq("t2.bad", 32'(bad_bit_ct_o), 32'd16);

    // 3: BURST k=0 L=3, window 8 cuts the third burst.
    do_reset("rst3");
    config_ch(2'd2, 0, 3, 2'b11, 8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'($urandom), 1'b1, "t3");
    check_eq("t3.active_before_cut", 32'(burst_active_o), 32'd1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 2'($urandom), 1'b1, "t3b");
    check_eq("t3.inj", 32'(inj_ct_o), 32'd8);
    check_eq("t3.bad", 32'(bad_bit_ct_o), 32'd16);
    check_eq("t3.active_after_cut", 32'(burst_active_o), 32'd0);

    // 4: RANDOM k=4, window 256, with idle gaps.
    do_reset("rst4");
    config_ch(2'd1, 4, 1, 2'b01, 256);
    nv = 0;
    inj_at_256 = -1;
    while (nv < 4096) begin
      if ($urandom_range(0, 3) != 0) begin
        err_mask_i = 2'($urandom_range(1, 3));
        cycle(1'b1, 2'($urandom), 1'b1, "t4");
        nv++;
        if (nv == 256) inj_at_256 = int'(inj_ct_o);
      end else begin
        cycle(1'b0, 2'($urandom), 1'b1, "t4g");
      end
    end
    check_eq("t4.inj_in_range", 32'(inj_ct_o >= 8 && inj_ct_o <= 32), 32'd1);
    check_eq("t4.inj_frozen", 32'(inj_ct_o), 32'(inj_at_256));

    // 5: BURST aborted by mode change, then by reset.
    do_reset("rst5");
    config_ch(2'd2, 0, 5, 2'b01, 0);
    cycle(1'b1, 2'b11, 1'b1, "t5");
    cycle(1'b1, 2'b11, 1'b1, "t5");
    mode_i = 2'd0;
    cycle(1'b1, 2'b11, 1'b1, "t5off");
    check_eq("t5.clean_err", 32'(err_o), 32'd0);
    check_eq("t5.active_off", 32'(burst_active_o), 32'd0);
    mode_i = 2'd2;
    cycle(1'b1, 2'b11, 1'b1, "t5");
    cycle(1'b1, 2'b11, 1'b1, "t5");
    do_reset("rst5b");
    check_eq("t5.rst_sym_o", 32'(sym_o), 32'd0);
    check_eq("t5.rst_active", 32'(burst_active_o), 32'd0);
    check_eq("t5.rst_inj", 32'(inj_ct_o), 32'd0);

    // 6: valid toggling, FIXED k=1; then saturation.
    config_ch(2'd3, 1, 1, 2'b11, 0);
    for (int i = 0; i < 32; i++) cycle(i % 2 == 0, 2'($urandom), 1'b1, "t6");
    check_eq("t6.sym_ct", 32'(sym_ct_o), 32'd16);
    check_eq("t6.inj", 32'(inj_ct_o), 32'd8);
    do_reset("rst6");
    config_ch(2'd3, 0, 1, 2'b11, 0);
    for (int i = 0; i < 65540; i++) cycle(1'b1, 2'($urandom), 1'b0, "t6s");
    compare_all("t6sat");
    check_eq("t6.sym_sat", 32'(sym_ct_o), 32'(CMAX));
    check_eq("t6.inj_sat", 32'(inj_ct_o), 32'(CMAX));
    check_eq("t6.bad_sat", 32'(bad_bit_ct_o), 32'(CMAX));
    window_i = 16'd5;
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'($urandom), 1'b1, "t6w");
    check_eq("t6.closed_err", 32'(err_o), 32'd0);
    window_i = 16'd0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'($urandom), 1'b1, "t6u");
    check_eq("t6.unlim_err", 32'(err_o), 32'd3);

    // 7: fully random configuration churn.
    do_reset("rst7");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        config_ch(2'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                                             : $urandom_range(0, 3),
                  $urandom_range(0, 15), 2'($urandom),
                  ($urandom_range(0, 2) == 0) ? 0 : m_sym_ct + $urandom_range(0, 60));
      end
      if ($urandom_range(0, 499) == 0) do_reset("rst7r");
      else cycle($urandom_range(0, 3) != 0, 2'($urandom), 1'b1, "t7");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
